// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One bit per cycle; result lands 32 edges after the accepting edge.
module mdu (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic [31:0] raw_q, raw_d;
   logic [1:0]  op_q, op_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        sgn;
   logic [31:0] mag_a, mag_b;
   logic [32:0] msum, rtry, rdiff;
   logic [63:0] mstep, dstep, step, mfin;
   logic [31:0] qmag, rmag;

   assign sgn   = ~op[0];
   assign mag_a = (sgn & rs_data[31]) ? -rs_data : rs_data;
   assign mag_b = (sgn & rt_data[31]) ? -rt_data : rt_data;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
   assign mstep = {msum, acc_q[31:1]};
   assign rtry  = {acc_q[63:32], acc_q[31]};
   assign rdiff = rtry - {1'b0, b_q};
   assign dstep = rdiff[32] ? {rtry[31:0], acc_q[30:0], 1'b0}
                            : {rdiff[31:0], acc_q[30:0], 1'b1};
   assign step  = op_q[1] ? dstep : mstep;

   assign mfin  = (sa_q ^ sb_q) ? -step : step;
   assign qmag  = step[31:0];
   assign rmag  = step[63:32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      raw_d   = raw_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = 5'd0;
               op_d    = op;
               sa_d    = sgn & rs_data[31];
               sb_d    = sgn & rt_data[31];
               raw_d   = rs_data;
               acc_d   = {32'd0, op[1] ? mag_a : mag_b};
               b_d     = op[1] ? mag_b : mag_a;
            end else begin
               if (mthi) hi_d = rs_data;
               if (mtlo) lo_d = rs_data;
            end
         end
         RUN: begin
            acc_d = step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!op_q[1]) begin
                  hi_d = mfin[63:32];
                  lo_d = mfin[31:0];
               end else if (b_q == 32'd0) begin
                  hi_d = raw_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  lo_d = (sa_q ^ sb_q) ? -qmag : qmag;
                  hi_d = sa_q ? -rmag : rmag;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         b_q     <= 32'd0;
         raw_q   <= 32'd0;
         op_q    <= 2'd0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         raw_q   <= raw_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001: Parameters: none; datapath width fixed at 32 bits.
REQ-002: One clock; reset is synchronous and active-high, ports named clk and rst.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: rst  input  1  synchronous active-high reset.
REQ-005: start  input  1  request a mult/div; sampled at rising edge.
REQ-006: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-007: rs_data  input  32  first operand (multiplicand/dividend), from register-file rs read port; also mthi/mtlo source.
REQ-008: rt_data  input  32  second operand (multiplier/divisor), from register-file rt read port.
REQ-009: mthi  input  1  write HI from rs_data.
REQ-010: mtlo  input  1  write LO from rs_data.
REQ-011: busy  output  1  operation in progress.
REQ-012: done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-013: hi  output  32  HI register (product upper word / remainder).
REQ-014: lo  output  32  LO register (product lower word / quotient).

Function
REQ-015: FSM states IDLE and RUN; transition IDLE->RUN on start at an edge with busy=0; RUN->IDLE after the 32nd iteration edge.
REQ-016: Accept edge: latch rs_data, rt_data, op; clear iteration counter; busy=1 from that edge.
REQ-017: Each subsequent edge in RUN performs one iteration (shift-add multiply or restoring divide, one bit per cycle) on operand magnitudes.
REQ-018: Edge 32 after accept: write final HI/LO (sign-corrected), busy=0, done=1; done returns to 0 on the next edge.
REQ-019: MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned per op.
REQ-020: DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, sign of remainder = sign of dividend (DIV).
REQ-021: Divide by zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = rs_data as latched; still 32-cycle latency.
REQ-022: DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000; no exception.
REQ-023: hi/lo hold their previous values throughout RUN until the REQ-018 edge.
REQ-024: start while busy=1: ignored, no effect on the operation in flight.
REQ-025: mthi/mtlo with busy=0 and start=0: hi/lo <= rs_data at that edge; both may assert together.
REQ-026: mthi/mtlo while busy=1, or in the same cycle as an accepted start: ignored.
REQ-027: Back-to-back: start asserted in the done cycle is accepted (busy=0 then).
REQ-028: Operands are combinationally passed through nowhere; outputs are registers only.

Reset
REQ-029: rst at any edge: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0; rst has priority over start, mthi, mtlo.
REQ-030: rst mid-operation aborts it; no done pulse is produced for the aborted operation.

Verification
REQ-031: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 32 cycles, done pulse once, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032: MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-034: DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035: start (MULTU 2x3) then start (MULTU 5x5) and mthi (rs=0xAA) at cycle 5 while busy -> single done, hi=0, lo=6; then mthi rs=0xAA idle -> hi=0xAA next edge.
REQ-036: rst asserted at iteration 10 of a DIV -> next cycle busy=0, hi=lo=0, no done; fresh start afterward completes normally in 32 cycles.
